// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch.
// Contents: FSM state enum, packed min:sec:cs time struct, field widths,
// digit limits and the borrow-correct lap delta helper used when
// LAP_STOPWATCH_DELTA_EN is defined.
package lap_stopwatch_pkg;

    localparam int unsigned MIN_W    = 6;
    localparam int unsigned SEC_W    = 6;
    localparam int unsigned CS_W     = 7;
    localparam int unsigned TIME_W   = MIN_W + SEC_W + CS_W;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned MAX_LAPS = 16;
    localparam int unsigned CS_MAX   = 99;
    localparam int unsigned SEC_MAX  = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SPLIT = 2'd2,
        ST_STOP  = 2'd3
    } sw_state_e;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [CS_W-1:0]  cs;
    } sw_time_t;

    // cur - prev with borrows through cs/sec; minutes wrap modulo min_max+1
    function automatic sw_time_t time_delta(input sw_time_t cur, input sw_time_t prev,
                                            input int unsigned min_max);
        sw_time_t   d;
        logic [7:0] c;
        logic [6:0] s;
        logic [6:0] m;
        logic       b_cs;
        logic       b_sec;
        c    = {1'b0, cur.cs} - {1'b0, prev.cs};
        b_cs = c[7];
        if (b_cs) c = c + 8'(CS_MAX + 1);
        d.cs = c[6:0];
        s     = {1'b0, cur.sec} - {1'b0, prev.sec} - 7'(b_cs);
        b_sec = s[6];
        if (b_sec) s = s + 7'(SEC_MAX + 1);
        d.sec = s[5:0];
        m = {1'b0, cur.min} - {1'b0, prev.min} - 7'(b_sec);
        if (m[6]) m = m + 7'(min_max + 1);
        d.min = m[5:0];
        return d;
    endfunction

endpackage

// File: rtl/lap_stopwatch_counter.sv
// Prescaled min:sec:cs time counter.
// Ports: clk, rst_n (async active-low), i_en (advance), i_clr (sync clear
// of prescaler and time), o_time (registered time), o_wrap_c (combinational
// pulse in the cycle the counter wraps past MIN_MAX:59.99).
module lap_stopwatch_counter
    import lap_stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned MIN_MAX  = 59
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_en,
    input  logic     i_clr,
    output sw_time_t o_time,
    output logic     o_wrap_c
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] r_presc;
    sw_time_t         r_time;
    logic             w_tick;
    logic             w_cs_last;
    logic             w_sec_last;
    logic             w_min_last;

    assign w_tick     = i_en && (r_presc == PRE_W'(TICK_DIV - 1));
    assign w_cs_last  = (r_time.cs  == CS_W'(CS_MAX));
    assign w_sec_last = (r_time.sec == SEC_W'(SEC_MAX));
    assign w_min_last = (r_time.min == MIN_W'(MIN_MAX));
    assign o_wrap_c   = w_tick && w_cs_last && w_sec_last && w_min_last;
    assign o_time     = r_time;

    // Prescaler keeps its fraction while disabled, so a resume continues mid-tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (i_clr) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (i_en) begin
            if (w_tick) begin
                r_presc <= '0;
                if (w_cs_last) begin
                    r_time.cs <= '0;
                    if (w_sec_last) begin
                        r_time.sec <= '0;
                        r_time.min <= w_min_last ? '0 : r_time.min + MIN_W'(1);
                    end else begin
                        r_time.sec <= r_time.sec + SEC_W'(1);
                    end
                end else begin
                    r_time.cs <= r_time.cs + CS_W'(1);
                end
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch with LAP_DEPTH-entry lap memory and split (frozen) display.
// Ports: clk, rst (async active-low), ss_btn / lap_btn (level buttons,
// rising edge = press), lap_rd_idx (lap entry select, 0 = oldest),
// disp_min/disp_sec/disp_cs (displayed time), running, split_active,
// lap_count, lap_full, lap_rd_data ({min,sec,cs}, combinational),
// time_ovf (sticky wrap flag).
// Build option: LAP_STOPWATCH_DELTA_EN stores lap-to-lap deltas instead of
// absolute times in the lap memory.
module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned MIN_MAX   = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_btn,
    input  logic              lap_btn,
    input  logic [IDX_W-1:0]  lap_rd_idx,
    output logic [MIN_W-1:0]  disp_min,
    output logic [SEC_W-1:0]  disp_sec,
    output logic [CS_W-1:0]   disp_cs,
    output logic              running,
    output logic              split_active,
    output logic [CNT_W-1:0]  lap_count,
    output logic              lap_full,
    output logic [TIME_W-1:0] lap_rd_data,
    output logic              time_ovf
);

    sw_state_e r_state;
    logic      r_ss_d;
    logic      r_lap_d;
    sw_time_t  r_hold;
    sw_time_t  r_lap_mem [MAX_LAPS];
    sw_time_t  w_time;
    sw_time_t  w_entry;
    logic      w_wrap_c;
    logic      w_ss_press;
    logic      w_lap_press;
    logic      w_push;
    logic      w_clear;
    logic      w_en;

    // Start/stop has priority: a simultaneous lap press is dropped
    assign w_ss_press  = ss_btn && !r_ss_d;
    assign w_lap_press = lap_btn && !r_lap_d && !w_ss_press;
    assign w_push      = (r_state == ST_RUN) && w_lap_press;
    assign w_clear     = (r_state == ST_STOP) && w_lap_press;
    assign w_en        = (r_state == ST_RUN) || (r_state == ST_SPLIT);

    lap_stopwatch_counter #(
        .TICK_DIV (TICK_DIV),
        .MIN_MAX  (MIN_MAX)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst),
        .i_en     (w_en),
        .i_clr    (w_clear),
        .o_time   (w_time),
        .o_wrap_c (w_wrap_c)
    );

`ifdef LAP_STOPWATCH_DELTA_EN
    sw_time_t r_last_abs;
    assign w_entry = time_delta(w_time, r_last_abs, MIN_MAX);
`else
    assign w_entry = w_time;
`endif

    // Button edge detect and control FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ss_d       <= 1'b0;
            r_lap_d      <= 1'b0;
            r_state      <= ST_IDLE;
            running      <= 1'b0;
            split_active <= 1'b0;
            r_hold       <= '0;
        end else begin
            r_ss_d  <= ss_btn;
            r_lap_d <= lap_btn;
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_press) begin
                        r_state <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_ss_press) begin
                        r_state <= ST_STOP;
                        running <= 1'b0;
                    end else if (w_lap_press) begin
                        r_state      <= ST_SPLIT;
                        split_active <= 1'b1;
                        r_hold       <= w_time;
                    end
                end
                ST_SPLIT: begin
                    if (w_ss_press) begin
                        r_state      <= ST_STOP;
                        running      <= 1'b0;
                        split_active <= 1'b0;
                    end else if (w_lap_press) begin
                        r_state      <= ST_RUN;
                        split_active <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (w_ss_press) begin
                        r_state <= ST_RUN;
                        running <= 1'b1;
                    end else if (w_lap_press) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    running      <= 1'b0;
                    split_active <= 1'b0;
                end
            endcase
        end
    end

    // Lap memory, lap count and sticky overflow; full memory drops new laps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LAPS; i++) r_lap_mem[i] <= '0;
            lap_count <= '0;
            lap_full  <= 1'b0;
            time_ovf  <= 1'b0;
`ifdef LAP_STOPWATCH_DELTA_EN
            r_last_abs <= '0;
`endif
        end else if (w_clear) begin
            lap_count <= '0;
            lap_full  <= 1'b0;
            time_ovf  <= 1'b0;
`ifdef LAP_STOPWATCH_DELTA_EN
            r_last_abs <= '0;
`endif
        end else begin
            if (w_wrap_c) time_ovf <= 1'b1;
            if (w_push) begin
`ifdef LAP_STOPWATCH_DELTA_EN
                r_last_abs <= w_time;
`endif
                if (!lap_full) begin
                    r_lap_mem[IDX_W'(lap_count)] <= w_entry;
                    lap_count <= lap_count + CNT_W'(1);
                    lap_full  <= ((lap_count + CNT_W'(1)) == CNT_W'(LAP_DEPTH));
                end
            end
        end
    end

    assign {disp_min, disp_sec, disp_cs} = (r_state == ST_SPLIT) ? r_hold : w_time;
    assign lap_rd_data = ({1'b0, lap_rd_idx} < lap_count) ? r_lap_mem[lap_rd_idx] : '0;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch with TICK_DIV=2, LAP_DEPTH=4, MIN_MAX=1.
// Expected times are kept as total centiseconds and converted to min:sec.cs.
module tb_lap_stopwatch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ss_btn = 1'b0;
    logic        lap_btn = 1'b0;
    logic [3:0]  lap_rd_idx = 4'd0;
    logic [5:0]  disp_min;
    logic [5:0]  disp_sec;
    logic [6:0]  disp_cs;
    logic        running;
    logic        split_active;
    logic [4:0]  lap_count;
    logic        lap_full;
    logic [18:0] lap_rd_data;
    logic        time_ovf;

    lap_stopwatch #(
        .TICK_DIV  (2),
        .LAP_DEPTH (4),
        .MIN_MAX   (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ss_btn       (ss_btn),
        .lap_btn      (lap_btn),
        .lap_rd_idx   (lap_rd_idx),
        .disp_min     (disp_min),
        .disp_sec     (disp_sec),
        .disp_cs      (disp_cs),
        .running      (running),
        .split_active (split_active),
        .lap_count    (lap_count),
        .lap_full     (lap_full),
        .lap_rd_data  (lap_rd_data),
        .time_ovf     (time_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ss;
        bit         lap;
        logic [3:0] idx;
        int         cyc;
        int         t_disp;
        bit         run;
        bit         split;
        int         cnt;
        int         rd;
        bit         ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef LAP_STOPWATCH_DELTA_EN
    localparam int E0 = 111, E1 = 21, E2 = 2, E3 = 2, L6A = 10, L6B = 15;
`else
    localparam int E0 = 111, E1 = 132, E2 = 134, E3 = 136, L6A = 10, L6B = 25;
`endif

    logic [46:0] w_obs;
    assign w_obs = {disp_min, disp_sec, disp_cs, running, split_active,
                    lap_count, lap_full, lap_rd_data, time_ovf};

    function automatic logic [18:0] tm(input int t);
        return {6'(t / 6000), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    function automatic logic [46:0] exp_bits(input int t_disp, input bit run, input bit split,
                                             input int cnt, input int rd, input bit ovf);
        logic full;
        full = (cnt == 4) ? 1'b1 : 1'b0;
        return {tm(t_disp), run, split, 5'(cnt), full, tm(rd), ovf};
    endfunction

    function automatic string fmt(input logic [46:0] b);
        return $sformatf("%0d:%0d.%0d run=%b split=%b cnt=%0d full=%b rd=%0d:%0d.%0d ovf=%b",
                         b[46:41], b[40:35], b[34:28], b[27], b[26], b[25:21], b[20],
                         b[19:14], b[13:8], b[7:1], b[0]);
    endfunction

    task automatic check(input string name, input logic [46:0] exp);
        n_vec++;
        if (w_obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %s, want %s", name, fmt(w_obs), fmt(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input bit ss, input bit lap, input int idx, input int cyc, input int t_disp,
                       input bit run, input bit split, input int cnt, input int rd, input bit ovf);
        vec_t v;
        v.ss = ss; v.lap = lap; v.idx = 4'(idx); v.cyc = cyc; v.t_disp = t_disp;
        v.run = run; v.split = split; v.cnt = cnt; v.rd = rd; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    initial begin
        //   ss lap idx  cyc   disp run spl cnt  rd  ovf
        add(0, 0, 0,     1,     0, 0, 0, 0,   0, 0);
        add(1, 0, 0,     1,     0, 1, 0, 0,   0, 0);
        add(0, 0, 0,   200,   100, 1, 0, 0,   0, 0);
        add(1, 0, 0,     1,   100, 0, 0, 0,   0, 0);
        add(0, 0, 0,    10,   100, 0, 0, 0,   0, 0);
        add(1, 0, 0,     1,   100, 1, 0, 0,   0, 0);
        add(0, 0, 0,     1,   101, 1, 0, 0,   0, 0);
        add(0, 0, 0,    20,   111, 1, 0, 0,   0, 0);
        add(0, 1, 0,     1,   111, 1, 1, 1,  E0, 0);
        add(0, 0, 0,    40,   111, 1, 1, 1,  E0, 0);
        add(0, 1, 0,     1,   132, 1, 0, 1,  E0, 0);
        add(0, 0, 0,     1,   132, 1, 0, 1,  E0, 0);
        add(0, 1, 0,     1,   132, 1, 1, 2,  E0, 0);
        add(0, 0, 0,     1,   132, 1, 1, 2,  E0, 0);
        add(0, 1, 0,     1,   134, 1, 0, 2,  E0, 0);
        add(0, 0, 0,     1,   134, 1, 0, 2,  E0, 0);
        add(0, 1, 0,     1,   134, 1, 1, 3,  E0, 0);
        add(0, 0, 0,     1,   134, 1, 1, 3,  E0, 0);
        add(0, 1, 0,     1,   136, 1, 0, 3,  E0, 0);
        add(0, 0, 0,     1,   136, 1, 0, 3,  E0, 0);
        add(0, 1, 0,     1,   136, 1, 1, 4,  E0, 0);
        add(0, 0, 0,     1,   136, 1, 1, 4,  E0, 0);
        add(0, 1, 0,     1,   138, 1, 0, 4,  E0, 0);
        add(0, 0, 0,     1,   138, 1, 0, 4,  E0, 0);
        add(0, 1, 0,     1,   138, 1, 1, 4,  E0, 0);
        add(0, 0, 1,     1,   138, 1, 1, 4,  E1, 0);
        add(0, 1, 2,     1,   140, 1, 0, 4,  E2, 0);
        add(0, 0, 3,     1,   140, 1, 0, 4,  E3, 0);
        add(0, 0, 5,     1,   141, 1, 0, 4,   0, 0);
        add(0, 0, 5, 23716, 11999, 1, 0, 4,   0, 0);
        add(0, 0, 5,     2,     0, 1, 0, 4,   0, 1);
        add(0, 0, 5,    10,     5, 1, 0, 4,   0, 1);
        add(1, 0, 5,     1,     5, 0, 0, 4,   0, 1);
        add(0, 1, 5,     1,     0, 0, 0, 0,   0, 0);
        add(0, 0, 5,     1,     0, 0, 0, 0,   0, 0);
        add(0, 1, 0,     1,     0, 0, 0, 0,   0, 0);
        add(0, 0, 0,     1,     0, 0, 0, 0,   0, 0);

        step(2);
        check("reset_state", exp_bits(0, 0, 0, 0, 0, 0));
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            ss_btn     = vecs[i].ss;
            lap_btn    = vecs[i].lap;
            lap_rd_idx = vecs[i].idx;
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i),
                  exp_bits(vecs[i].t_disp, vecs[i].run, vecs[i].split,
                           vecs[i].cnt, vecs[i].rd, vecs[i].ovf));
        end

        // Simultaneous presses in RUN: stop wins, no lap recorded
        lap_rd_idx = 4'd0;
        ss_btn = 1'b1; step(1);
        ss_btn = 1'b0; step(4);
        lap_btn = 1'b1; step(1);
        lap_btn = 1'b0; step(1);
        lap_btn = 1'b1; step(1);
        lap_btn = 1'b0; step(1);
        ss_btn = 1'b1; lap_btn = 1'b1; step(1);
        check("both_press", exp_bits(4, 0, 0, 1, 2, 0));
        ss_btn = 1'b0; lap_btn = 1'b0; step(1);
        check("both_release", exp_bits(4, 0, 0, 1, 2, 0));
        ss_btn = 1'b1; step(1);
        ss_btn = 1'b0; step(3);
        check("resume_fraction", exp_bits(6, 1, 0, 1, 2, 0));

        // Asynchronous reset mid-run, no clock edge in between
        rst = 1'b0;
        #1;
        check("async_reset", exp_bits(0, 0, 0, 0, 0, 0));
        rst = 1'b1;

        // Two laps at 00:00.10 and 00:00.25
        ss_btn = 1'b1; step(1);
        ss_btn = 1'b0; step(20);
        lap_btn = 1'b1; step(1);
        lap_btn = 1'b0; step(1);
        lap_btn = 1'b1; step(1);
        lap_btn = 1'b0; step(27);
        lap_btn = 1'b1; step(1);
        check("lap2_split", exp_bits(25, 1, 1, 2, L6A, 0));
        lap_rd_idx = 4'd1; #1;
        check("lap2_entry1", exp_bits(25, 1, 1, 2, L6B, 0));
        lap_rd_idx = 4'd2; #1;
        check("lap2_entry2_empty", exp_bits(25, 1, 1, 2, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
